// File: rtl/data_mem_responder.sv
// Load/store responder over a word-organised RAM: one request at a time, byte/half/word
// lanes with sign/zero-extended loads, and a one-cycle ready pulse after WAIT_STATES busy cycles.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] mem_read,
    output logic        ready,
    output logic        err
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    state_t        state, state_next;
    logic [3:0]    wait_cnt;
    logic          capture, commit;

    logic [31:0]   req_addr, req_data;
    size_t         req_size;
    logic          req_unsigned, req_rd, req_wr;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word, store_word, load_word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic          range_bad, req_err;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (rd_en | wr_en) begin
                state_next = BUSY;
                capture    = 1'b1;
            end
            BUSY: if (wait_cnt == 4'd0) begin
                state_next = DONE;
                commit     = 1'b1;
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request operands are only meaningful between capture and commit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            req_addr     <= addr;
            req_data     <= mem_write;
            req_size     <= size_t'(size);
            req_unsigned <= unsigned_ld;
            req_rd       <= rd_en;
            req_wr       <= wr_en;
        end
    end

    assign lane      = req_addr[1:0];
    assign word_idx  = req_addr[AW+1:2];
    assign cur_word  = ram[word_idx];
    assign byte_val  = cur_word[{lane, 3'b000} +: 8];
    assign half_val  = cur_word[{lane[1], 4'b0000} +: 16];
    assign range_bad = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

    assign req_err = (req_rd & req_wr)
                   | (req_size == SZ_BAD)
                   | ((req_size == SZ_HALF) & lane[0])
                   | ((req_size == SZ_WORD) & (lane != 2'b00))
                   | range_bad;

    always_comb begin
        store_word = cur_word;
        load_word  = '0;
        case (req_size)
            SZ_BYTE: begin
                store_word[{lane, 3'b000} +: 8] = req_data[7:0];
                load_word = {{24{byte_val[7] & ~req_unsigned}}, byte_val};
            end
            SZ_HALF: begin
                store_word[{lane[1], 4'b0000} +: 16] = req_data[15:0];
                load_word = {{16{half_val[15] & ~req_unsigned}}, half_val};
            end
            SZ_WORD: begin
                store_word = req_data;
                load_word  = cur_word;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            mem_read <= '0;
            err      <= 1'b0;
        end else begin
            if (capture) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == BUSY && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                err      <= req_err;
                mem_read <= (req_err || !req_rd) ? 32'd0 : load_word;
            end
        end
    end

    // NOTE: the RAM array is never reset; reset only gates the write so an abandoned store is lost.
    always_ff @(posedge clk) begin
        if (rst && commit && req_wr && !req_err) begin
            ram[word_idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at WAIT_STATES 0, 1 and 3
// exercising lanes, extension, error rejection, latency, back-to-back and reset abort.
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       rd_en = '0, wr_en = '0, unsigned_ld = '0;
    logic [2:0][31:0] addr = '0, mem_write = '0;
    logic [2:0][1:0]  size = '0;
    logic [2:0][31:0] mem_read;
    logic [2:0]       ready, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .mem_write(mem_write[0]), .size(size[0]), .unsigned_ld(unsigned_ld[0]),
        .mem_read(mem_read[0]), .ready(ready[0]), .err(err[0]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .mem_write(mem_write[1]), .size(size[1]), .unsigned_ld(unsigned_ld[1]),
        .mem_read(mem_read[1]), .ready(ready[1]), .err(err[1]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .rd_en(rd_en[2]), .wr_en(wr_en[2]), .addr(addr[2]),
        .mem_write(mem_write[2]), .size(size[2]), .unsigned_ld(unsigned_ld[2]),
        .mem_read(mem_read[2]), .ready(ready[2]), .err(err[2]));

    function automatic vec_t vec(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] exp_d, input logic exp_e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.sz = sz; v.uns = uns;
        v.exp_d = exp_d; v.exp_e = exp_e;
        return v;
    endfunction

    // Issue one request on instance d in cycle C0; lat is the cycle offset at which ready is seen.
    // Returns in the idle cycle after the ready pulse.
    task automatic do_req(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          output int lat, output logic [31:0] rdata, output logic rerr);
        @(negedge clk);
        rd_en[d] = rd; wr_en[d] = wr; addr[d] = a; mem_write[d] = wd;
        size[d] = sz; unsigned_ld[d] = uns;
        @(posedge clk); #1;
        rd_en[d] = 1'b0; wr_en[d] = 1'b0;
        addr[d] = 32'($urandom); mem_write[d] = 32'($urandom);
        size[d] = 2'($urandom_range(3, 0)); unsigned_ld[d] = 1'($urandom_range(1, 0));
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = mem_read[d];
        rerr  = err[d];
        if (lat >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL req_timeout dut%0d: no ready within %0d cycles", d, lat);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_width dut%0d: ready=%b one cycle after pulse, required 0", d, ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ({ready[d], err[d]} !== 2'b00 || mem_read[d] !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d cyc%0d: ready=%b err=%b mem_read=%h, required 0/0/0",
                             d, c, ready[d], err[d], mem_read[d]);
                end
            end
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd_v; logic e;
        do_req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, lat, rd_v, e);
        n_checks++;
        if (lat != 3 || e !== 1'b0 || rd_v !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_word: lat=%0d err=%b data=%h, required 3/0/00000000", lat, e, rd_v);
        end
        do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rd_v, e);
        n_checks++;
        if (lat != 3 || e !== 1'b0 || rd_v !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_word: lat=%0d err=%b data=%h, required 3/0/deadbeef", lat, e, rd_v);
        end
    endtask

    task automatic test_lanes();
        vec_t v[$];
        int lat; logic [31:0] rd_v; logic e;
        v.push_back(vec(0, 1, 32'h20, 32'h00000000, 2'b10, 0, 32'h00000000, 0)); // sw 0
        v.push_back(vec(0, 1, 32'h22, 32'h12345680, 2'b00, 0, 32'h00000000, 0)); // sb 0x80
        v.push_back(vec(1, 0, 32'h22, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0)); // lb
        v.push_back(vec(1, 0, 32'h22, 32'h0,        2'b00, 1, 32'h00000080, 0)); // lbu
        v.push_back(vec(0, 1, 32'h20, 32'hABCD8001, 2'b01, 0, 32'h00000000, 0)); // sh 0x8001
        v.push_back(vec(1, 0, 32'h20, 32'h0,        2'b10, 0, 32'h00808001, 0)); // lw
        v.push_back(vec(1, 0, 32'h20, 32'h0,        2'b01, 0, 32'hFFFF8001, 0)); // lh
        v.push_back(vec(1, 0, 32'h22, 32'h0,        2'b01, 1, 32'h00000080, 0)); // lhu
        v.push_back(vec(1, 0, 32'h22, 32'h0,        2'b01, 0, 32'h00000080, 0)); // lh, positive
        v.push_back(vec(1, 0, 32'h21, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0)); // lb lane 1
        v.push_back(vec(1, 0, 32'h20, 32'h0,        2'b00, 1, 32'h00000001, 0)); // lbu lane 0
        v.push_back(vec(1, 0, 32'h20, 32'h0,        2'b10, 1, 32'h00808001, 0)); // lw ignores uns
        v.push_back(vec(0, 1, 32'h00, 32'h0BADF00D, 2'b10, 0, 32'h00000000, 0)); // sw clears data
        foreach (v[i]) begin
            do_req(1, v[i].rd, v[i].wr, v[i].a, v[i].wd, v[i].sz, v[i].uns, lat, rd_v, e);
            n_checks++;
            if (rd_v !== v[i].exp_d || e !== v[i].exp_e || lat != 3) begin
                n_fail++;
                $display("FAIL lanes[%0d] addr=%h: data=%h err=%b lat=%0d, required %h/%b/3",
                         i, v[i].a, rd_v, e, lat, v[i].exp_d, v[i].exp_e);
            end
        end
    endtask

    task automatic test_errors();
        vec_t v[$];
        int lat; logic [31:0] rd_v; logic e;
        v.push_back(vec(1, 0, 32'h21,  32'h0,        2'b10, 0, 32'h0,        1)); // misaligned lw
        v.push_back(vec(1, 0, 32'h20,  32'h0,        2'b10, 0, 32'h00808001, 0));
        v.push_back(vec(0, 1, 32'h23,  32'h0000FFFF, 2'b01, 0, 32'h0,        1)); // misaligned sh
        v.push_back(vec(1, 0, 32'h20,  32'h0,        2'b10, 0, 32'h00808001, 0));
        v.push_back(vec(0, 1, 32'h20,  32'hFFFFFFFF, 2'b11, 0, 32'h0,        1)); // size 11
        v.push_back(vec(1, 0, 32'h20,  32'h0,        2'b10, 0, 32'h00808001, 0));
        v.push_back(vec(1, 1, 32'h20,  32'h11111111, 2'b10, 0, 32'h0,        1)); // rd and wr
        v.push_back(vec(1, 0, 32'h20,  32'h0,        2'b10, 0, 32'h00808001, 0));
        v.push_back(vec(0, 1, 32'h100, 32'hCAFEF00D, 2'b10, 0, 32'h0,        1)); // out of range
        v.push_back(vec(1, 0, 32'h00,  32'h0,        2'b10, 0, 32'h0BADF00D, 0)); // aliased word intact
        v.push_back(vec(1, 0, 32'h100, 32'h0,        2'b10, 0, 32'h0,        1)); // out-of-range load
        foreach (v[i]) begin
            do_req(1, v[i].rd, v[i].wr, v[i].a, v[i].wd, v[i].sz, v[i].uns, lat, rd_v, e);
            n_checks++;
            if (rd_v !== v[i].exp_d || e !== v[i].exp_e || lat != 3) begin
                n_fail++;
                $display("FAIL errors[%0d] addr=%h: data=%h err=%b lat=%0d, required %h/%b/3",
                         i, v[i].a, rd_v, e, lat, v[i].exp_d, v[i].exp_e);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_hold: err=%b after ready fell, required 1", err[1]);
        end
    endtask

    task automatic test_latency();
        int lat; logic [31:0] rd_v; logic e;
        for (int d = 0; d < 3; d += 2) begin
            int exp_lat;
            exp_lat = (d == 0) ? 2 : 5;
            do_req(d, 1'b0, 1'b1, 32'h8, 32'h55AA00FF, 2'b10, 1'b0, lat, rd_v, e);
            n_checks++;
            if (lat != exp_lat || e !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_sw dut%0d: lat=%0d err=%b, required %0d/0", d, lat, e, exp_lat);
            end
            do_req(d, 1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, lat, rd_v, e);
            n_checks++;
            if (lat != exp_lat || rd_v !== 32'h55AA00FF) begin
                n_fail++;
                $display("FAIL latency_lw dut%0d: lat=%0d data=%h, required %0d/55aa00ff",
                         d, lat, rd_v, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d += 2) begin
            int ws, r1, r2, extra;
            logic [31:0] d2;
            ws = (d == 0) ? 0 : 3;
            r1 = -1; r2 = -1; extra = 0; d2 = '0;
            @(negedge clk);
            rd_en[d] = 1'b1; wr_en[d] = 1'b0; addr[d] = 32'h8; size[d] = 2'b10; unsigned_ld[d] = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (r1 >= 0 && k == r1 + 2) rd_en[d] = 1'b0;
                if (ready[d] === 1'b1) begin
                    if (r1 < 0)      r1 = k;
                    else if (r2 < 0) begin r2 = k; d2 = mem_read[d]; end
                    else             extra++;
                end
            end
            n_checks++;
            if (r1 != 2 + ws || r2 != r1 + 3 + ws || extra != 0 || d2 !== 32'h55AA00FF) begin
                n_fail++;
                $display("FAIL back_to_back dut%0d: ready at %0d,%0d extra=%0d data=%h, required %0d,%0d/0/55aa00ff",
                         d, r1, r2, extra, d2, 2 + ws, 5 + 2 * ws);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd_v; logic e;
        int seen;
        do_req(2, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 2'b10, 1'b0, lat, rd_v, e);
        // reset in the second BUSY cycle, then reset on the commit edge
        for (int hit = 2; hit <= 4; hit += 2) begin
            @(negedge clk);
            rd_en[2] = 1'b0; wr_en[2] = 1'b1; addr[2] = 32'h40; mem_write[2] = 32'h12345678;
            size[2] = 2'b10;
            for (int k = 1; k <= hit; k++) begin
                @(posedge clk); #1;
                wr_en[2] = 1'b0;
            end
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (ready[2] === 1'b1) seen++;
            end
            n_checks++;
            if (seen != 0 || err[1] !== 1'b0 || mem_read[2] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_abort@%0d: ready pulses=%0d err1=%b mem_read=%h, required 0/0/00000000",
                         hit, seen, err[1], mem_read[2]);
            end
            do_req(2, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, lat, rd_v, e);
            n_checks++;
            if (rd_v !== 32'hA5A5A5A5 || e !== 1'b0 || lat != 5) begin
                n_fail++;
                $display("FAIL reset_nowrite@%0d: data=%h err=%b lat=%0d, required a5a5a5a5/0/5",
                         hit, rd_v, e, lat);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder that sits on the load/store side of the control unit. It accepts one read or write request at a time and performs byte, halfword or word accesses on an internal word-organised RAM. Loads are returned sign- or zero-extended. Completion is signalled with a one-cycle `ready` pulse after a programmable number of wait states, so the control unit can be exercised against non-zero memory latency.

## Interface

Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the RAM. Valid word index is `addr[31:2] < DEPTH_WORDS`.
- `WAIT_STATES`, 1: extra cycles spent in BUSY before the access commits. Legal range is 0..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rd_en`  in  1  load request.
- `wr_en`  in  1  store request.
- `addr`  in  32  byte address.
- `mem_write`  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- `size`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `unsigned_ld`  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
- `mem_read`  out  32  load result, valid while `ready` = 1.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `ready`; 1 means the request was rejected.

## Operation

- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `rd_en | wr_en` is high at a clock edge, capture `addr`, `mem_write`, `size`, `unsigned_ld`, and the request type.
  - Load the wait counter with `WAIT_STATES` and move to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - If counter ≠ 0, decrement it and stay in BUSY.
  - If counter = 0, commit the access (below), register `mem_read`/`err`, and move to DONE.
- **DONE**
  - `ready` = 1 for exactly one cycle, then return to IDLE unconditionally.
  - Request inputs are ignored while in BUSY and DONE.
- **Error checks** are evaluated on the captured request at commit. Any of the following sets `err` = 1, suppresses the RAM write, and forces `mem_read` = 0:
  - `rd_en` and `wr_en` both high at capture;
  - `size` = 11;
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - `addr[31:2] >= DEPTH_WORDS`.
- **Store**: read-modify-write of word `addr[31:2]`.
  - Byte: lane `addr[1:0]` ← `mem_write[7:0]`.
  - Half: lanes `{addr[1],0}` and `{addr[1],1}` ← `mem_write[15:0]`.
  - Word: all four lanes.
  - Other lanes are unchanged.
  - `mem_read` = 0 on a store.
- **Load**: select the addressed byte or half from the word, then:
  - `unsigned_ld` = 0: sign-extend from bit 7 or 15;
  - `unsigned_ld` = 1: zero-extend.
  - Word loads ignore `unsigned_ld`.
- Arithmetic: the wait counter is 4 bits and never wraps (decrement happens only when ≠ 0). Lane offset is `addr[1:0]`; the upper address bits are used only for the range check.

## Timing

- Reset (`rst` = 0 at an edge), from any state:
  - state ← IDLE, counter ← 0, `ready` ← 0, `err` ← 0, `mem_read` ← 0.
  - RAM contents are not reset.
  - Reset in BUSY abandons the request; no write occurs.
  - Reset coinciding with the commit edge also suppresses the write.
- Latency: a request first high in cycle C0 gets `ready` = 1 in cycle C0 + 2 + `WAIT_STATES`. With `WAIT_STATES` = 0 that is C0 + 2.
- The requester holds `rd_en`/`wr_en` and operands until capture; they may change freely afterwards.
- The requester must drop `rd_en`/`wr_en` no later than the `ready` cycle. A request still high in the cycle after `ready` is treated as a new request.
- Back-to-back throughput: one request per `3 + WAIT_STATES` cycles.
- `mem_read` and `err` are registered. They hold their last value after `ready` falls and update only at the next commit or reset.
- A store followed by a load of the same word returns the new data; the write commits before the load is captured.

## Test plan

- **Reset and idle**: hold `rst` = 0 for 2 cycles, then release with no request → `ready`/`err`/`mem_read` stay 0 indefinitely.
- **Word store/load, WAIT_STATES = 1**:
  - sw 0xDEADBEEF to addr 0x10 → `ready` in C0+3, `err` = 0.
  - lw 0x10 → `mem_read` = 0xDEADBEEF.
- **Byte/half lanes and extension**, after sw 0x00000000 to 0x20:
  - sb 0x80 to 0x22;
  - lb 0x22 → 0xFFFFFF80;
  - lbu 0x22 → 0x00000080;
  - sh 0x8001 to 0x20, then lw 0x20 → 0x00808001.
- **Error cases**, each → `ready` with `err` = 1, `mem_read` = 0, and a following lw of the containing word shows it unchanged:
  - lw 0x21;
  - sh 0x23;
  - `size` = 11;
  - `rd_en` = `wr_en` = 1;
  - addr = `4*DEPTH_WORDS`.
- **Latency sweep**: `WAIT_STATES` = 0 and 3 → `ready` exactly at C0+2 and C0+5. Holding `rd_en` one extra cycle after `ready` produces a second `ready` 3+`WAIT_STATES` cycles later.
- **Reset mid-operation**: sw 0x12345678 to 0x40 with `WAIT_STATES` = 3, assert `rst` in the second BUSY cycle → no `ready`. A later lw 0x40 returns the prior contents.
